ro_pair_comparator: RTL and testbench
=====================================

RO_PAIR_COMPARATOR -- requirements
Module: ro_pair_comparator

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of each edge counter.
REQ-002 SHALL have parameter WINDOW, default 1024: measurement window length in clk cycles, at least 1.
REQ-003 SHALL have parameter SETTLE, default 8: clk cycles the ring oscillators run before counting starts, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: measurement request, sampled only in IDLE.
REQ-007 SHALL have ports ro_a and ro_b, input, 1 bit each: ring-oscillator outputs, asynchronous to clk.
REQ-008 SHALL have port ro_en, output, 1 bit: enable driven to both ring oscillators.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 SHALL have port resp, output, 1 bit: PUF response bit, 1 when count_a > count_b.
REQ-012 SHALL have port tie, output, 1 bit: 1 when count_a == count_b.
REQ-013 SHALL have ports count_a and count_b, output, COUNT_W bits each: final edge counts.

Function
REQ-014 SHALL pass each of ro_a and ro_b through a two-flop synchronizer followed by one history flop.
REQ-015 SHALL detect a rising edge of an input as sync = 1 and history = 0.
REQ-016 SHALL use the FSM states IDLE, SETTLE, COUNT and DONE.
REQ-017 SHALL move from IDLE to SETTLE on the edge where start = 1.
REQ-018 SHALL stay in SETTLE for exactly SETTLE cycles, then go to COUNT.
REQ-019 SHALL stay in COUNT for exactly WINDOW cycles, then go to DONE.
REQ-020 SHALL spend one cycle in DONE, then return to IDLE.
REQ-021 SHALL drive ro_en = 1 in SETTLE and COUNT only, and 0 otherwise.
REQ-022 SHALL clear both counters to 0 on entry to SETTLE.
REQ-023 SHALL increment a counter only in COUNT cycles where its rising edge is detected.
REQ-024 SHALL saturate each counter at 2^COUNT_W-1, with no wrap-around.
REQ-025 SHALL capture count_a, count_b, resp and tie into output registers on entry to DONE.
REQ-026 SHALL hold count_a, count_b, resp and tie until the next DONE.
REQ-027 SHALL, when start is accepted at edge k, assert done during cycle k+1+SETTLE+WINDOW.
REQ-028 SHALL keep busy = 1 from cycle k+1 through the done cycle.
REQ-029 SHALL ignore start while busy, including in DONE; start held high re-arms on the first IDLE cycle.
REQ-030 SHALL set resp = 0 and tie = 1 on equal counts.
REQ-031 SHALL compare saturated counts, so two saturated counters give tie = 1.

Reset
REQ-032 SHALL, while rst_n = 0, force the state to IDLE and clear the synchronizers, history flops and counters.
REQ-033 SHALL, while rst_n = 0, drive ro_en, busy, done, resp, tie, count_a and count_b to 0.
REQ-034 SHALL abort any in-progress measurement on reset, with no done pulse.
REQ-035 SHALL, after rst_n deasserts, accept start on the first rising clk edge.

Configuration
REQ-036 SHALL use the macro RO_CMP_COUNTS_EN to control the count outputs.
REQ-037 SHALL, with RO_CMP_COUNTS_EN defined, drive count_a and count_b from their output registers.
REQ-038 SHALL, without RO_CMP_COUNTS_EN, tie count_a and count_b to 0 and omit their output registers.
REQ-039 SHALL keep resp and tie behaviour identical with and without RO_CMP_COUNTS_EN.

Verification
REQ-040 SHALL cover: SETTLE=4, WINDOW=16, ro_a toggling every 2 clk, ro_b every 4 clk, start at cycle 0 -> done at cycle 21, count_a=4, count_b=2, resp=1, tie=0.
REQ-041 SHALL cover: same setup with ro_a and ro_b swapped -> count_a=2, count_b=4, resp=0, tie=0.
REQ-042 SHALL cover: both inputs toggling every 4 clk -> count_a=count_b=2, resp=0, tie=1.
REQ-043 SHALL cover: COUNT_W=2, ro_a toggling every clk, ro_b every 8 clk -> count_a=3 (saturated), count_b=1, resp=1.
REQ-044 SHALL cover: rst_n pulsed low in cycle 10 of COUNT -> all outputs 0 immediately, no done; a new start -> normal result 21 cycles later.
REQ-045 SHALL cover: start held high continuously -> done every 22 cycles, start ignored while busy, ro_en=0 in DONE and IDLE cycles.

Source files
------------

// File: rtl/ro_pair_comparator.sv
// ro_pair_comparator: ring-oscillator pair PUF cell comparator.
// Runs both ring oscillators for a settle period, counts rising edges of
// each over a fixed window, then reports which oscillator was faster.
// Optional feature macro: RO_CMP_COUNTS_EN. When it is defined, count_a and
// count_b expose the captured edge counts. When it is undefined, they read 0
// and their output registers are not built.
// Handshake: start is a request that is sampled only in IDLE. There is no
// ready signal; while busy=1 any request is ignored. done is a one-cycle valid
// pulse, and resp/tie/count_* stay stable from that pulse until the next one.
// dbg_state_o exposes the FSM state: 0=IDLE 1=SETTLE 2=COUNT 3=DONE.
module ro_pair_comparator #(
    parameter int COUNT_W = 16,
    parameter int WINDOW  = 1024,
    parameter int SETTLE  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ro_a,
    input  logic               ro_b,
    output logic               ro_en,
    output logic               busy,
    output logic               done,
    output logic               resp,
    output logic               tie,
    output logic [COUNT_W-1:0] count_a,
    output logic [COUNT_W-1:0] count_b,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // One down-counter serves both the settle and the window phases.
    localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0]   SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]   WINDOW_LD = TMR_W'(WINDOW - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               clr_cnt, cnt_en, capture;

    logic               ro_a_s1_q, ro_a_s2_q, ro_a_h_q;
    logic               ro_b_s1_q, ro_b_s2_q, ro_b_h_q;
    logic               rise_a, rise_b;

    logic [COUNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [COUNT_W-1:0] cnt_b_q, cnt_b_d;
    logic               resp_q, tie_q;

    // State and phase timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        busy    = 1'b1;
        ro_en   = 1'b0;
        done    = 1'b0;
        clr_cnt = 1'b0;
        cnt_en  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_SETTLE;
                    tmr_d   = SETTLE_LD;
                    clr_cnt = 1'b1;
                end
            end
            S_SETTLE: begin
                ro_en = 1'b1;
                if (tmr_q == '0) begin
                    state_d = S_COUNT;
                    tmr_d   = WINDOW_LD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_COUNT: begin
                ro_en  = 1'b1;
                cnt_en = 1'b1;
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-flop synchronizers plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_a_s1_q <= 1'b0;
            ro_a_s2_q <= 1'b0;
            ro_a_h_q  <= 1'b0;
            ro_b_s1_q <= 1'b0;
            ro_b_s2_q <= 1'b0;
            ro_b_h_q  <= 1'b0;
        end else begin
            ro_a_s1_q <= ro_a;
            ro_a_s2_q <= ro_a_s1_q;
            ro_a_h_q  <= ro_a_s2_q;
            ro_b_s1_q <= ro_b;
            ro_b_s2_q <= ro_b_s1_q;
            ro_b_h_q  <= ro_b_s2_q;
        end
    end

    assign rise_a = ro_a_s2_q & ~ro_a_h_q;
    assign rise_b = ro_b_s2_q & ~ro_b_h_q;

    // Saturating edge counters, cleared when a measurement is accepted.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (clr_cnt) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else if (cnt_en) begin
            if (rise_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + COUNT_W'(1);
            if (rise_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + COUNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Result capture on entry to DONE, using the counts including the last window cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= 1'b0;
            tie_q  <= 1'b0;
        end else if (capture) begin
            resp_q <= (cnt_a_d > cnt_b_d);
            tie_q  <= (cnt_a_d == cnt_b_d);
        end
    end

    assign resp        = resp_q;
    assign tie         = tie_q;
    assign dbg_state_o = state_q;

`ifdef RO_CMP_COUNTS_EN
    logic [COUNT_W-1:0] count_a_q, count_b_q;

    // Count output registers, loaded together with resp/tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_a_q <= '0;
            count_b_q <= '0;
        end else if (capture) begin
            count_a_q <= cnt_a_d;
            count_b_q <= cnt_b_d;
        end
    end

    assign count_a = count_a_q;
    assign count_b = count_b_q;
`else
    assign count_a = '0;
    assign count_b = '0;
`endif

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Bench for ro_pair_comparator: two instances (16-bit and 2-bit counters)
// share clock, reset, start and oscillator stimulus; SETTLE=4, WINDOW=16.
`timescale 1ns/1ps
module tb_ro_pair_comparator;

    localparam int SET = 4;
    localparam int WIN = 16;
`ifdef RO_CMP_COUNTS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ro_a = 1'b0;
    logic ro_b = 1'b0;

    logic        m_ro_en, m_busy, m_done, m_resp, m_tie;
    logic [15:0] m_count_a, m_count_b;
    logic [1:0]  m_dbg;
    logic        s_ro_en, s_busy, s_done, s_resp, s_tie;
    logic [1:0]  s_count_a, s_count_b;
    logic [1:0]  s_dbg;

    int total = 0;
    int bad = 0;
    int div_a = 0;
    int div_b = 0;
    int cyc = 0;

    ro_pair_comparator #(.COUNT_W(16), .WINDOW(WIN), .SETTLE(SET)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(m_ro_en), .busy(m_busy), .done(m_done), .resp(m_resp), .tie(m_tie),
        .count_a(m_count_a), .count_b(m_count_b), .dbg_state_o(m_dbg)
    );

    ro_pair_comparator #(.COUNT_W(2), .WINDOW(WIN), .SETTLE(SET)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .resp(s_resp), .tie(s_tie),
        .count_a(s_count_a), .count_b(s_count_b), .dbg_state_o(s_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Oscillator model: each input toggles every div_* clock cycles (0 = stopped).
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ro_a = (div_a == 0) ? 1'b0 : 1'((cyc / div_a) % 2);
            ro_b = (div_b == 0) ? 1'b0 : 1'((cyc / div_b) % 2);
        end
    end

    function automatic logic [15:0] exp_m(input int v);
        return CNT_ON ? 16'(v) : 16'd0;
    endfunction

    function automatic logic [1:0] exp_s(input int v);
        return CNT_ON ? 2'(v) : 2'd0;
    endfunction

    // Driver: one measurement. Cycle 0 has start=1; done is due in cycle 21.
    task automatic run_meas(input bit rel_rst, output int done_n, output int seq_err);
        done_n = -1;
        seq_err = 0;
        @(negedge clk);
        start = 1'b1;
        if (rel_rst) rst_n = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_done === 1'b1 && done_n < 0) done_n = n;
            if (m_busy !== (n <= 21)) seq_err++;
            if (m_ro_en !== (n <= 20)) seq_err++;
            if (m_done !== (n == 21)) seq_err++;
            if (s_done !== (n == 21)) seq_err++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", m_busy); end
        total++; if (m_ro_en !== 1'b0) begin bad++; $display("FAIL rst_ro_en: got %0b want 0", m_ro_en); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", m_done); end
        total++; if ({m_resp, m_tie} !== 2'b00) begin bad++; $display("FAIL rst_resp_tie: got %b want 00", {m_resp, m_tie}); end
        total++; if ({m_count_a, m_count_b} !== 32'd0) begin bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", m_count_a, m_count_b); end
        total++; if (m_dbg !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", m_dbg); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_a_faster();
        int dn, se;
        div_a = 2; div_b = 4;
        run_meas(1'b0, dn, se);
        total++; if (dn != 21) begin bad++; $display("FAIL a_fast_latency: got %0d want 21", dn); end
        total++; if (se != 0) begin bad++; $display("FAIL a_fast_sequence: got %0d errors want 0", se); end
        total++; if (m_resp !== 1'b1) begin bad++; $display("FAIL a_fast_resp: got %0b want 1", m_resp); end
        total++; if (m_tie !== 1'b0) begin bad++; $display("FAIL a_fast_tie: got %0b want 0", m_tie); end
        total++; if (m_count_a !== exp_m(4)) begin bad++; $display("FAIL a_fast_count_a: got %0d want %0d", m_count_a, exp_m(4)); end
        total++; if (m_count_b !== exp_m(2)) begin bad++; $display("FAIL a_fast_count_b: got %0d want %0d", m_count_b, exp_m(2)); end
    endtask

    task automatic test_b_faster();
        int dn, se;
        div_a = 4; div_b = 2;
        run_meas(1'b0, dn, se);
        total++; if (dn != 21 || se != 0) begin bad++; $display("FAIL b_fast_timing: got done=%0d err=%0d want 21/0", dn, se); end
        total++; if (m_resp !== 1'b0) begin bad++; $display("FAIL b_fast_resp: got %0b want 0", m_resp); end
        total++; if (m_tie !== 1'b0) begin bad++; $display("FAIL b_fast_tie: got %0b want 0", m_tie); end
        total++; if (m_count_a !== exp_m(2)) begin bad++; $display("FAIL b_fast_count_a: got %0d want %0d", m_count_a, exp_m(2)); end
        total++; if (m_count_b !== exp_m(4)) begin bad++; $display("FAIL b_fast_count_b: got %0d want %0d", m_count_b, exp_m(4)); end
    endtask

    task automatic test_tie();
        int dn, se;
        div_a = 4; div_b = 4;
        run_meas(1'b0, dn, se);
        total++; if (dn != 21 || se != 0) begin bad++; $display("FAIL tie_timing: got done=%0d err=%0d want 21/0", dn, se); end
        total++; if (m_resp !== 1'b0) begin bad++; $display("FAIL tie_resp: got %0b want 0", m_resp); end
        total++; if (m_tie !== 1'b1) begin bad++; $display("FAIL tie_tie: got %0b want 1", m_tie); end
        total++; if ({m_count_a, m_count_b} !== {exp_m(2), exp_m(2)}) begin bad++; $display("FAIL tie_counts: got %0d/%0d want %0d/%0d", m_count_a, m_count_b, exp_m(2), exp_m(2)); end
    endtask

    task automatic test_saturation();
        int dn, se;
        div_a = 1; div_b = 8;
        run_meas(1'b0, dn, se);
        total++; if (dn != 21 || se != 0) begin bad++; $display("FAIL sat_timing: got done=%0d err=%0d want 21/0", dn, se); end
        total++; if (s_count_a !== exp_s(3)) begin bad++; $display("FAIL sat_count_a: got %0d want %0d", s_count_a, exp_s(3)); end
        total++; if (s_count_b !== exp_s(1)) begin bad++; $display("FAIL sat_count_b: got %0d want %0d", s_count_b, exp_s(1)); end
        total++; if ({s_resp, s_tie} !== 2'b10) begin bad++; $display("FAIL sat_resp_tie: got %b want 10", {s_resp, s_tie}); end
        total++; if (m_count_a !== exp_m(8)) begin bad++; $display("FAIL wide_count_a: got %0d want %0d", m_count_a, exp_m(8)); end
        total++; if ({m_resp, m_tie} !== 2'b10) begin bad++; $display("FAIL wide_resp_tie: got %b want 10", {m_resp, m_tie}); end
    endtask

    task automatic test_both_saturated();
        int dn, se;
        div_a = 1; div_b = 1;
        run_meas(1'b0, dn, se);
        total++; if (dn != 21 || se != 0) begin bad++; $display("FAIL both_sat_timing: got done=%0d err=%0d want 21/0", dn, se); end
        total++; if ({s_resp, s_tie} !== 2'b01) begin bad++; $display("FAIL both_sat_resp_tie: got %b want 01", {s_resp, s_tie}); end
        total++; if ({s_count_a, s_count_b} !== {exp_s(3), exp_s(3)}) begin bad++; $display("FAIL both_sat_counts: got %0d/%0d want %0d/%0d", s_count_a, s_count_b, exp_s(3), exp_s(3)); end
        total++; if ({m_resp, m_tie} !== 2'b01) begin bad++; $display("FAIL both_wide_resp_tie: got %b want 01", {m_resp, m_tie}); end
    endtask

    task automatic test_reset_abort();
        int dn, se, early;
        early = 0;
        div_a = 2; div_b = 4;
        run_meas(1'b0, dn, se);
        // Start a measurement and reset it in its 10th COUNT cycle (cycle 14).
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_done === 1'b1) early++;
        end
        total++; if (m_dbg !== 2'd2) begin bad++; $display("FAIL abort_pre_state: got %0d want 2", m_dbg); end
        rst_n = 1'b0;
        #1;
        total++; if ({m_busy, m_ro_en, m_done} !== 3'b000) begin bad++; $display("FAIL abort_ctrl: got %b want 000", {m_busy, m_ro_en, m_done}); end
        total++; if ({m_resp, m_tie} !== 2'b00) begin bad++; $display("FAIL abort_resp_tie: got %b want 00", {m_resp, m_tie}); end
        total++; if ({m_count_a, m_count_b} !== 32'd0) begin bad++; $display("FAIL abort_counts: got %0d/%0d want 0/0", m_count_a, m_count_b); end
        @(negedge clk);
        if (m_done === 1'b1) early++;
        total++; if (early != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", early); end
        // Release reset with start already high: accepted on the first edge.
        run_meas(1'b1, dn, se);
        total++; if (dn != 21 || se != 0) begin bad++; $display("FAIL post_reset_timing: got done=%0d err=%0d want 21/0", dn, se); end
        total++; if ({m_resp, m_tie} !== 2'b10) begin bad++; $display("FAIL post_reset_resp_tie: got %b want 10", {m_resp, m_tie}); end
        total++; if (m_count_a !== exp_m(4)) begin bad++; $display("FAIL post_reset_count_a: got %0d want %0d", m_count_a, exp_m(4)); end
    endtask

    task automatic test_start_held();
        int ndone, pos_err, busy_err, en_err, resp_err;
        ndone = 0; pos_err = 0; busy_err = 0; en_err = 0; resp_err = 0;
        div_a = 2; div_b = 4;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                ndone++;
                if (n != 21 && n != 43 && n != 65) pos_err++;
                if (m_resp !== 1'b1) resp_err++;
            end
            if (m_busy !== !(n == 22 || n == 44 || n == 66)) busy_err++;
            if ((m_done === 1'b1 || m_busy === 1'b0) && m_ro_en !== 1'b0) en_err++;
            if (n == 65) start = 1'b0;
        end
        total++; if (ndone != 3) begin bad++; $display("FAIL held_done_count: got %0d want 3", ndone); end
        total++; if (pos_err != 0) begin bad++; $display("FAIL held_done_spacing: got %0d misplaced want 0", pos_err); end
        total++; if (busy_err != 0) begin bad++; $display("FAIL held_busy: got %0d errors want 0", busy_err); end
        total++; if (en_err != 0) begin bad++; $display("FAIL held_ro_en: got %0d errors want 0", en_err); end
        total++; if (resp_err != 0) begin bad++; $display("FAIL held_resp: got %0d errors want 0", resp_err); end
    endtask

    initial begin
        test_reset();
        test_a_faster();
        test_b_faster();
        test_tie();
        test_saturation();
        test_both_saturated();
        test_reset_abort();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
